risc_prog_ctrl: RTL and testbench
=================================

RISC_PROG_CTRL -- requirements
Module: risc_prog_ctrl

Interface
REQ-001 SHALL have one clock and one asynchronous active-high reset; ports listed below, clock and reset first.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port byte_valid, input, 1 bit: host byte present.
REQ-005 SHALL have port byte_data, input, 8 bits: host command or payload byte.
REQ-006 SHALL have port byte_ready, output, 1 bit: controller can accept a byte; a byte transfers on a cycle with byte_valid=1 and byte_ready=1.
REQ-007 SHALL have port mem_we, output, 1 bit: instruction-memory write strobe.
REQ-008 SHALL have port mem_addr, output, 7 bits: instruction-memory address.
REQ-009 SHALL have port mem_data, output, 8 bits: instruction-memory write data.
REQ-010 SHALL have port cpu_run, output, 1 bit: 1 = CPU released from reset and executing; 0 = CPU held in reset.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at end of a load or a run.
REQ-012 SHALL have port err, output, 1 bit: sticky protocol error flag.

Function
REQ-013 SHALL implement states IDLE, LD_ADDR, LD_CNT, LD_DATA, RUN_CNT, RUNNING.
REQ-014 SHALL drive byte_ready=1 in every state when rst=0; throughput is one byte per cycle.
REQ-015 In IDLE, accepted byte 0x01 (LOAD) SHALL go to LD_ADDR; 0x02 (RUN) SHALL go to RUN_CNT; any other value SHALL set err and stay in IDLE.
REQ-016 Accepting 0x01 or 0x02 in IDLE SHALL clear err on the same edge.
REQ-017 In LD_ADDR, accepted byte bits [6:0] SHALL become the write pointer; bit 7 is ignored; next state LD_CNT.
REQ-018 In LD_CNT, accepted byte SHALL set the remaining count N (0x00 means 128); next state LD_DATA.
REQ-019 In LD_DATA, each accepted byte SHALL produce mem_we=1, mem_addr=pointer, mem_data=byte on the following cycle (latency 1, registered outputs).
REQ-020 After each data write, pointer SHALL increment modulo 128 (0x7F wraps to 0x00) and N SHALL decrement.
REQ-021 When the Nth data byte is accepted, state SHALL return to IDLE; done SHALL pulse in the same cycle as the final mem_we.
REQ-022 mem_we SHALL be 0 on every cycle without a data write; mem_addr and mem_data SHALL hold their last values.
REQ-023 In RUN_CNT, accepted byte SHALL load cycle limit L; next state RUNNING; cpu_run SHALL go to 1 on the following cycle.
REQ-024 For L in 1..255, cpu_run SHALL stay high for exactly L cycles, then drop to 0; state returns to IDLE; done pulses in the first cycle cpu_run=0.
REQ-025 For L=0, cpu_run SHALL stay high until a HALT byte (0x03) is accepted.
REQ-026 In RUNNING, accepted 0x03 SHALL drop cpu_run to 0 on the next cycle, return to IDLE, and pulse done in that cycle.
REQ-027 In RUNNING, any other accepted byte SHALL set err, be discarded, and leave cpu_run and the cycle count unaffected.
REQ-028 If HALT is accepted on the same cycle the limit expires, the controller SHALL produce a single stop: cpu_run low once, one done pulse.
REQ-029 mem_we SHALL never be 1 while cpu_run=1.
REQ-030 Idle cycles (byte_valid=0) in any state SHALL leave state, pointer, N, and the run count unchanged, except the run count in RUNNING.

Reset
REQ-031 rst=1 SHALL immediately, asynchronously, force state IDLE and the following outputs: byte_ready=0, mem_we=0, mem_addr=0x00, mem_data=0x00, cpu_run=0, done=0, err=0.
REQ-032 Reset during LD_DATA or RUNNING SHALL abort the operation with no further write and no done pulse; cpu_run=0 while rst=1.
REQ-033 After rst deasserts, byte_ready SHALL be 1 from the first rising edge.

Verification
REQ-034 Load with wrap: bytes 01,7E,03,AA,BB,CC -> writes (7E,AA),(7F,BB),(00,CC) on consecutive cycles; done coincides with the CC write; state returns to IDLE.
REQ-035 Bounded run: bytes 02,05 -> cpu_run high exactly 5 cycles starting 1 cycle after 05 is accepted; done pulses once; no mem_we occurs.
REQ-036 Unbounded run and halt: bytes 02,00, 20 idle cycles, then 03 -> cpu_run high 21 cycles; cpu_run low and done=1 in the cycle after 03 is accepted.
REQ-037 Error path: byte 55 in IDLE -> err=1; byte 07 during RUNNING -> err stays 1, run unaffected; later byte 01 in IDLE -> err=0.
REQ-038 Full load and reset abort: bytes 01,00,00 and 128 data bytes -> addresses 00..7F written; repeat the sequence and assert rst after 10 data bytes -> exactly 10 writes, all outputs at reset values, no done.
REQ-039 Simultaneous stop: bytes 02,03, with 03 accepted on the 3rd run cycle -> cpu_run high 3 cycles and exactly one done pulse.

Source files
------------

// File: rtl/risc_prog_ctrl.sv
// Program-load / run controller: streams host bytes into instruction memory
// and gates the CPU's run window from a byte-oriented command protocol.
module risc_prog_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       mem_we,
    output logic [6:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       cpu_run,
    output logic       done,
    output logic       err
);

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned CNT_W  = 8;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_HALT = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_ADDR,
        S_LD_CNT,
        S_LD_DATA,
        S_RUN_CNT,
        S_RUNNING
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [CNT_W-1:0]    load_cnt;
    logic [CNT_W-1:0]    run_cnt;
    logic                fire_c;
    logic                halt_c;
    logic                expire_c;

    assign fire_c   = byte_valid & byte_ready;
    assign halt_c   = fire_c && (byte_data == CMD_HALT);
    // A loaded limit of zero never reaches one, so the run is unbounded.
    assign expire_c = (run_cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            load_cnt   <= '0;
            run_cnt    <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_run    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_ready <= 1'b1;
            mem_we     <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fire_c) begin
                        if (byte_data == CMD_LOAD) begin
                            state <= S_LD_ADDR;
                            err   <= 1'b0;
                        end else if (byte_data == CMD_RUN) begin
                            state <= S_RUN_CNT;
                            err   <= 1'b0;
                        end else begin
                            err   <= 1'b1;
                        end
                    end
                end
                S_LD_ADDR: begin
                    if (fire_c) begin
                        ptr   <= byte_data[ADDR_W-1:0];
                        state <= S_LD_CNT;
                    end
                end
                S_LD_CNT: begin
                    if (fire_c) begin
                        load_cnt <= (byte_data == 8'h00) ? CNT_W'(128) : byte_data;
                        state    <= S_LD_DATA;
                    end
                end
                S_LD_DATA: begin
                    if (fire_c) begin
                        mem_we   <= 1'b1;
                        mem_addr <= ptr;
                        mem_data <= byte_data;
                        ptr      <= ptr + ADDR_W'(1);
                        load_cnt <= load_cnt - CNT_W'(1);
                        if (load_cnt == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_RUN_CNT: begin
                    if (fire_c) begin
                        run_cnt <= byte_data;
                        cpu_run <= 1'b1;
                        state   <= S_RUNNING;
                    end
                end
                S_RUNNING: begin
                    // HALT and limit expiry on the same edge collapse into one stop.
                    if (halt_c || expire_c) begin
                        cpu_run <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end else if (run_cnt != '0) begin
                        run_cnt <= run_cnt - CNT_W'(1);
                    end
                    if (fire_c && !halt_c) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cpu_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_prog_ctrl.sv
// Directed bench for risc_prog_ctrl: a negedge monitor logs writes, done
// pulses and run windows; each scenario task checks its own expectations.
module tb_risc_prog_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_run;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    risc_prog_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_run    (cpu_run),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Cycle monitor, labelled by the negedge count at which outputs are seen.
    int         cyc       = 0;
    int         n_we      = 0;
    int         n_done    = 0;
    int         n_run     = 0;
    int         run_first = 0;
    int         run_last  = 0;
    int         done_cyc  = 0;
    int         we_run    = 0;
    logic       run_prev  = 1'b0;
    logic [6:0] wr_addr [0:511];
    logic [7:0] wr_data [0:511];
    int         wr_cyc  [0:511];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_we === 1'b1) begin
            if (n_we < 512) begin
                wr_addr[n_we] <= mem_addr;
                wr_data[n_we] <= mem_data;
                wr_cyc[n_we]  <= cyc;
            end
            n_we <= n_we + 1;
        end
        if (done === 1'b1) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (cpu_run === 1'b1) begin
            n_run    <= n_run + 1;
            run_last <= cyc;
            if (run_prev !== 1'b1) run_first <= cyc;
        end
        if (mem_we === 1'b1 && cpu_run === 1'b1) we_run <= we_run + 1;
        run_prev <= cpu_run;
    end

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #1 rst = 1'b1;
        #1;
        total++;
        if ({byte_ready, mem_we, mem_addr, mem_data, cpu_run, done, err} !== 19'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h run=%b done=%b err=%b, want all zero",
                     byte_ready, mem_we, mem_addr, mem_data, cpu_run, done, err);
        end
        repeat (2) @(negedge clk);
        total++;
        if (byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_held: got %b want 0", byte_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b want 1", byte_ready);
        end
    endtask

    task automatic test_load_wrap;
        int w0, d0, c;
        logic [6:0] ea [3];
        logic [7:0] ed [3];
        ea = '{7'h7E, 7'h7F, 7'h00};
        ed = '{8'hAA, 8'hBB, 8'hCC};
        w0 = n_we;
        d0 = n_done;
        put(8'h01); put(8'h7E); put(8'h03); put(8'hAA); put(8'hBB); put(8'hCC);
        c = cyc;
        idle(4);
        total++;
        if (n_we - w0 !== 3) begin
            bad++;
            $display("FAIL wrap_write_count: got %0d want 3", n_we - w0);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wr_addr[w0+i] !== ea[i] || wr_data[w0+i] !== ed[i] || wr_cyc[w0+i] !== c - 1 + i) begin
                bad++;
                $display("FAIL wrap_write%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                         i, wr_addr[w0+i], wr_data[w0+i], wr_cyc[w0+i], ea[i], ed[i], c - 1 + i);
            end
        end
        total++;
        if (n_done - d0 !== 1 || done_cyc !== c + 1) begin
            bad++;
            $display("FAIL wrap_done: got count=%0d cyc=%0d want count=1 cyc=%0d", n_done - d0, done_cyc, c + 1);
        end
        put(8'h55);
        idle(2);
        total++;
        if (err !== 1'b1 || n_we - w0 !== 3) begin
            bad++;
            $display("FAIL wrap_back_to_idle: got err=%b writes=%0d want err=1 writes=3", err, n_we - w0);
        end
    endtask

    task automatic test_bounded_run;
        int w0, d0, r0, c;
        w0 = n_we; d0 = n_done; r0 = n_run;
        put(8'h02); put(8'h05);
        c = cyc;
        idle(8);
        total++;
        if (n_run - r0 !== 5 || run_first !== c + 1 || run_last !== c + 5) begin
            bad++;
            $display("FAIL bounded_run: got cycles=%0d first=%0d last=%0d want 5/%0d/%0d",
                     n_run - r0, run_first, run_last, c + 1, c + 5);
        end
        total++;
        if (n_done - d0 !== 1 || done_cyc !== c + 6) begin
            bad++;
            $display("FAIL bounded_done: got count=%0d cyc=%0d want 1/%0d", n_done - d0, done_cyc, c + 6);
        end
        total++;
        if (n_we - w0 !== 0 || err !== 1'b0) begin
            bad++;
            $display("FAIL bounded_side: got writes=%0d err=%b want 0/0", n_we - w0, err);
        end
    endtask

    task automatic test_unbounded_halt;
        int d0, r0, c;
        d0 = n_done; r0 = n_run;
        put(8'h02); put(8'h00);
        c = cyc;
        idle(20);
        total++;
        if (cpu_run !== 1'b1) begin
            bad++;
            $display("FAIL unbounded_still_running: got %b want 1", cpu_run);
        end
        put(8'h03);
        idle(3);
        total++;
        if (n_run - r0 !== 21 || run_first !== c + 1 || run_last !== c + 21) begin
            bad++;
            $display("FAIL unbounded_run: got cycles=%0d first=%0d last=%0d want 21/%0d/%0d",
                     n_run - r0, run_first, run_last, c + 1, c + 21);
        end
        total++;
        if (n_done - d0 !== 1 || done_cyc !== c + 22) begin
            bad++;
            $display("FAIL halt_done: got count=%0d cyc=%0d want 1/%0d", n_done - d0, done_cyc, c + 22);
        end
    endtask

    task automatic test_error_path;
        int w0, d0, r0, c;
        put(8'h55);
        idle(1);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_idle_bad_cmd: got %b want 1", err);
        end
        d0 = n_done; r0 = n_run;
        put(8'h02); put(8'h04);
        c = cyc;
        idle(1);
        put(8'h07);
        idle(1);
        total++;
        if (err !== 1'b1 || cpu_run !== 1'b1) begin
            bad++;
            $display("FAIL err_during_run: got err=%b run=%b want 1/1", err, cpu_run);
        end
        idle(5);
        total++;
        if (n_run - r0 !== 4 || run_first !== c + 1 || n_done - d0 !== 1 || done_cyc !== c + 5) begin
            bad++;
            $display("FAIL err_run_unaffected: got cycles=%0d first=%0d dones=%0d dcyc=%0d want 4/%0d/1/%0d",
                     n_run - r0, run_first, n_done - d0, done_cyc, c + 1, c + 5);
        end
        put(8'h01);
        idle(1);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_cleared_by_load: got %b want 0", err);
        end
        w0 = n_we;
        put(8'h90); put(8'h01); put(8'h5A);
        idle(3);
        total++;
        if (n_we - w0 !== 1 || wr_addr[w0] !== 7'h10 || wr_data[w0] !== 8'h5A) begin
            bad++;
            $display("FAIL err_then_load: got writes=%0d addr=%h data=%h want 1/10/5a",
                     n_we - w0, wr_addr[w0], wr_data[w0]);
        end
    endtask

    task automatic test_full_load_abort;
        int w0, d0;
        w0 = n_we; d0 = n_done;
        put(8'h01); put(8'h00); put(8'h00);
        for (int i = 0; i < 128; i++) put(8'(i) ^ 8'h3C);
        idle(4);
        total++;
        if (n_we - w0 !== 128 || n_done - d0 !== 1) begin
            bad++;
            $display("FAIL full_load_counts: got writes=%0d dones=%0d want 128/1", n_we - w0, n_done - d0);
        end
        for (int i = 0; i < 128; i++) begin
            total++;
            if (wr_addr[w0+i] !== 7'(i) || wr_data[w0+i] !== (8'(i) ^ 8'h3C)) begin
                bad++;
                $display("FAIL full_load_entry%0d: got addr=%h data=%h want addr=%h data=%h",
                         i, wr_addr[w0+i], wr_data[w0+i], 7'(i), 8'(i) ^ 8'h3C);
            end
        end
        w0 = n_we; d0 = n_done;
        put(8'h01); put(8'h00); put(8'h00);
        for (int i = 0; i < 10; i++) put(8'(i) + 8'h80);
        @(negedge clk);
        byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({byte_ready, mem_we, mem_addr, mem_data, cpu_run, done, err} !== 19'h0) begin
            bad++;
            $display("FAIL abort_reset_outputs: got rdy=%b we=%b addr=%h data=%h run=%b done=%b err=%b, want all zero",
                     byte_ready, mem_we, mem_addr, mem_data, cpu_run, done, err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(3);
        total++;
        if (n_we - w0 !== 10 || n_done - d0 !== 0 || byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_counts: got writes=%0d dones=%0d rdy=%b want 10/0/1",
                     n_we - w0, n_done - d0, byte_ready);
        end
    endtask

    task automatic test_simultaneous_stop;
        int d0, r0, c;
        d0 = n_done; r0 = n_run;
        put(8'h02); put(8'h03);
        c = cyc;
        idle(2);
        put(8'h03);
        idle(6);
        total++;
        if (n_run - r0 !== 3 || run_last !== c + 3) begin
            bad++;
            $display("FAIL simul_run: got cycles=%0d last=%0d want 3/%0d", n_run - r0, run_last, c + 3);
        end
        total++;
        if (n_done - d0 !== 1 || done_cyc !== c + 4 || err !== 1'b0) begin
            bad++;
            $display("FAIL simul_done: got count=%0d cyc=%0d err=%b want 1/%0d/0",
                     n_done - d0, done_cyc, err, c + 4);
        end
    endtask

    initial begin
        test_reset();
        test_load_wrap();
        test_bounded_run();
        test_unbounded_halt();
        test_error_path();
        test_full_load_abort();
        test_simultaneous_stop();
        total++;
        if (we_run !== 0) begin
            bad++;
            $display("FAIL we_while_run: got %0d overlapping cycles want 0", we_run);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
